// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: pipeline sequencing for the 5-stage MIPS datapath.
// Decides each cycle whether PC, IF/ID, ID/EX and EX/MEM advance, hold,
// flush or take a bubble. Covers load-use stalls, taken-branch flushes and
// multi-cycle mul/div occupancy of EX.
// Optional build macro HAZARD_PERF_CNT_EN adds StallCycles/FlushCount
// performance counters.
module hazard_stall_controller #(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned CNT_W   = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [4:0] ID_Rs,
  input  logic [4:0] ID_Rt,
  input  logic       ID_UsesRt,
  input  logic       ID_IsMulDiv,
  input  logic       EX_MemRead,
  input  logic [4:0] EX_WriteReg,
  input  logic       EX_BranchTaken,
  output logic       PCHold,
  output logic       IFIDHold,
  output logic       IFIDFlush,
  output logic       IDEXHold,
  output logic       IDEXBubble,
  output logic       EXMEMBubble,
  output logic       Busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] StallCycles,
  output logic [15:0] FlushCount
`endif
);

  typedef enum logic {
    RUN      = 1'b0,
    MUL_WAIT = 1'b1
  } state_t;

  // Remaining EX occupancy loaded when a mul/div issues.
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MUL_LAT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;

  // $0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign load_use = EX_MemRead && (EX_WriteReg != 5'd0) &&
                    ((EX_WriteReg == ID_Rs) ||
                     (ID_UsesRt && (EX_WriteReg == ID_Rt)));

  // State and occupancy counter register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and stage-control decode; reset forces every control low.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    PCHold      = 1'b0;
    IFIDHold    = 1'b0;
    IFIDFlush   = 1'b0;
    IDEXHold    = 1'b0;
    IDEXBubble  = 1'b0;
    EXMEMBubble = 1'b0;
    Busy        = 1'b0;
    if (!Reset) begin
      unique case (state_q)
        RUN: begin
          if (EX_BranchTaken) begin
            // Instruction in ID is on the wrong path: its hazards are moot.
            IFIDFlush  = 1'b1;
            IDEXBubble = 1'b1;
          end else if (load_use) begin
            PCHold     = 1'b1;
            IFIDHold   = 1'b1;
            IDEXBubble = 1'b1;
          end else if (ID_IsMulDiv && (MUL_LAT > 1)) begin
            state_d = MUL_WAIT;
            cnt_d   = LAT_M1;
          end
        end
        MUL_WAIT: begin
          PCHold      = 1'b1;
          IFIDHold    = 1'b1;
          IDEXHold    = 1'b1;
          EXMEMBubble = 1'b1;
          Busy        = 1'b1;
          cnt_d       = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = RUN;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [15:0] flush_count_q;

  // Performance counters; both wrap naturally at their width.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (PCHold)    stall_cycles_q <= stall_cycles_q + 32'd1;
      if (IFIDFlush) flush_count_q  <= flush_count_q + 16'd1;
    end
  end

  assign StallCycles = stall_cycles_q;
  assign FlushCount  = flush_count_q;
`endif

endmodule
